// File: rtl/mem_pkg.sv
// Shared state encoding and address constants for the memory-access stage.
// Latency/backpressure: none (types and constants only).
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } mem_state_e;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;
    localparam int          RAM_ADDR_W         = 18;

endpackage

// File: rtl/mem_access_fsm.sv
// Access sequencer: loads take 2 stalled cycles + DONE, stores take 4 stalled cycles + DONE.
// Backpressure: stall is raised combinationally on a request in IDLE; requests outside IDLE are ignored.
module mem_access_fsm
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    input  logic sel_udata,
    input  logic sel_ustat,
    output logic accept,
    output logic rd_cap,
    output logic bus_drv,
    output logic stall,
    output logic ram_en_n,
    output logic ram_oe_n,
    output logic ram_we_n,
    output logic uart_rd_n,
    output logic uart_wr_n
);

    mem_state_e state_q, state_d;
    logic       is_rd, is_wr, is_pulse, sram_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    state_d = WR_SETUP;
                end else if (mem_read) begin
                    state_d = RD;
                end
            end
            RD:       state_d = DONE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        is_rd    = (state_q == RD);
        is_wr    = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
        is_pulse = (state_q == WR_PULSE);
        sram_sel = !sel_udata && !sel_ustat;
        accept   = (state_q == IDLE) && (mem_read || mem_write);
        stall    = accept || is_rd || is_wr;
        rd_cap   = is_rd;
        bus_drv  = is_wr;
        ram_en_n = !(sram_sel && (is_rd || is_wr));
        ram_oe_n = !(sram_sel && is_rd);
        ram_we_n = !(sram_sel && is_pulse);
`ifdef UART_MMIO_EN
        uart_rd_n = !(sel_udata && is_rd);
        uart_wr_n = !(sel_udata && is_pulse);
`else
        uart_rd_n = 1'b1;
        uart_wr_n = 1'b1;
`endif
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: address/data/load registers and shared bus; UART_MMIO_EN maps the UART registers.
// Load result valid in DONE (cycle 2), store completes in cycle 4; Stall holds the pipeline meanwhile.
module mem_access
    import mem_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [15:0]           ALURes,
    input  logic [15:0]           WData,
    output logic [15:0]           MemData,
    output logic                  Stall,
    output logic [RAM_ADDR_W-1:0] RamAddr,
    inout  wire  [15:0]           RamData,
    output logic                  RamEN_n,
    output logic                  RamOE_n,
    output logic                  RamWE_n,
    output logic                  UartRd_n,
    output logic                  UartWr_n,
    input  logic                  UartDataReady,
    input  logic                  UartTbre,
    input  logic                  UartTsre
);

    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic        sel_udata, sel_ustat;
    logic        accept, rd_cap, bus_drv;

`ifdef UART_MMIO_EN
    assign sel_udata = (addr_q == UART_DATA_ADDR);
    assign sel_ustat = (addr_q == UART_STAT_ADDR);
`else
    logic unused_uart;
    assign sel_udata   = 1'b0;
    assign sel_ustat   = 1'b0;
    assign unused_uart = &{1'b0, UartDataReady, UartTbre, UartTsre, UART_DATA_ADDR, UART_STAT_ADDR};
`endif

    mem_access_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (MemRead),
        .mem_write (MemWrite),
        .sel_udata (sel_udata),
        .sel_ustat (sel_ustat),
        .accept    (accept),
        .rd_cap    (rd_cap),
        .bus_drv   (bus_drv),
        .stall     (Stall),
        .ram_en_n  (RamEN_n),
        .ram_oe_n  (RamOE_n),
        .ram_we_n  (RamWE_n),
        .uart_rd_n (UartRd_n),
        .uart_wr_n (UartWr_n)
    );

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        if (accept) begin
            addr_d  = ALURes;
            wdata_d = WData;
        end
        // Loads sample the bus on the edge that leaves RD.
        if (rd_cap) begin
            mem_data_d = RamData;
`ifdef UART_MMIO_EN
            if (sel_ustat) begin
                mem_data_d = {14'b0, UartDataReady, UartTbre & UartTsre};
            end else if (sel_udata) begin
                mem_data_d = {8'h00, RamData[7:0]};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            mem_data_q <= 16'h0000;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign MemData = mem_data_q;
    assign RamAddr = {{(RAM_ADDR_W-16){1'b0}}, addr_q};
    assign RamData = bus_drv ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed table, reset-mid-write sequence and random traffic vs a behavioural model.
module tb_mem_access;

    localparam int T_SRAM  = 0;
    localparam int T_UDATA = 1;
    localparam int T_USTAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] alu_res, wdata;
    logic [15:0] mem_data;
    logic        stall;
    logic [17:0] ram_addr;
    wire  [15:0] ram_bus;
    logic        ram_en_n, ram_oe_n, ram_we_n;
    logic        uart_rd_n, uart_wr_n;
    logic        uart_rdy, uart_tbre, uart_tsre;

    logic [15:0] sram [0:65535];
    logic [15:0] uart_rx;
    logic        park;

    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_md;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead       (mem_read),
        .MemWrite      (mem_write),
        .ALURes        (alu_res),
        .WData         (wdata),
        .MemData       (mem_data),
        .Stall         (stall),
        .RamAddr       (ram_addr),
        .RamData       (ram_bus),
        .RamEN_n       (ram_en_n),
        .RamOE_n       (ram_oe_n),
        .RamWE_n       (ram_we_n),
        .UartRd_n      (uart_rd_n),
        .UartWr_n      (uart_wr_n),
        .UartDataReady (uart_rdy),
        .UartTbre      (uart_tbre),
        .UartTsre      (uart_tsre)
    );

    // External devices: asynchronous SRAM, UART data port, and a parking driver used to prove high-Z.
    assign ram_bus = (!ram_en_n && !ram_oe_n) ? sram[ram_addr[15:0]] : 16'hzzzz;
    assign ram_bus = (!uart_rd_n) ? uart_rx : 16'hzzzz;
    assign ram_bus = park ? 16'h5A5A : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram_en_n && !ram_we_n) sram[ram_addr[15:0]] <= ram_bus;
    end

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic int tgt(input logic [15:0] a);
`ifdef UART_MMIO_EN
        if (a == 16'hBF00) return T_UDATA;
        if (a == 16'hBF01) return T_USTAT;
`endif
        return T_SRAM;
    endfunction

    function automatic logic [15:0] model_load(input logic [15:0] a);
        case (tgt(a))
            T_UDATA: return {8'h00, uart_rx[7:0]};
            T_USTAT: return {14'b0, uart_rdy, uart_tbre & uart_tsre};
            default: return ref_mem.exists(a) ? ref_mem[a] : pat(a);
        endcase
    endfunction

    // {Stall, RamEN_n, RamOE_n, RamWE_n, UartRd_n, UartWr_n} expected k cycles after the request.
    function automatic logic [5:0] exp_vec(input int k, input logic wr, input int t);
        int         n;
        logic [5:0] v;
        n = wr ? 4 : 2;
        v = 6'b011111;
        if (k < n) v[5] = 1'b1;
        if (!wr && k == 1) begin
            if (t == T_SRAM) begin
                v[4] = 1'b0;
                v[3] = 1'b0;
            end else if (t == T_UDATA) begin
                v[1] = 1'b0;
            end
        end
        if (wr && k >= 1 && k <= 3 && t == T_SRAM) v[4] = 1'b0;
        if (wr && k == 2) begin
            if (t == T_SRAM) v[2] = 1'b0;
            else if (t == T_UDATA) v[0] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [5:0] cur_vec();
        return {stall, ram_en_n, ram_oe_n, ram_we_n, uart_rd_n, uart_wr_n};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_md, input string name);
        int n;
        int t;
        n = wr ? 4 : 2;
        t = tgt(a);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        alu_res   = a;
        wdata     = d;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("%s strobes k=%0d", name, k), {26'b0, cur_vec()}, {26'b0, exp_vec(k, wr, t)});
            if (k == 1 || (wr && k == 3))
                check($sformatf("%s addr k=%0d", name, k), {14'b0, ram_addr}, {16'b0, a});
            if (wr && k >= 1 && k <= 3)
                check($sformatf("%s bus k=%0d", name, k), {16'b0, ram_bus}, {16'b0, d});
            if (k == n)
                check($sformatf("%s memdata", name), {16'b0, mem_data}, {16'b0, exp_md});
        end
        if (wr && t == T_SRAM) ref_mem[a] = d;
        ref_md = exp_md;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_md;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] st_md;
        for (int i = 0; i < 65536; i++) sram[i] = pat(16'(i));
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_res = 16'h0; wdata = 16'h0;
        uart_rdy = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0; uart_rx = 16'h7E41;
        park = 1'b1; ref_md = 16'h0000;

        // Reset state.
        #12;
        check("reset strobes", {26'b0, cur_vec()}, 32'h1F);
        check("reset memdata", {16'b0, mem_data}, 32'h0);
        check("reset addr", {14'b0, ram_addr}, 32'h0);
        check("reset bus", {16'b0, ram_bus}, 32'h5A5A);
        @(negedge clk);
        rst = 1'b1;
        park = 1'b0;

        // Directed table; UART-mapped addresses have build-dependent results.
`ifdef UART_MMIO_EN
        st_md = 16'h0002;
`else
        st_md = pat(16'hBF01);
`endif
        tbl.push_back('{1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000});
        tbl.push_back('{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF});
        tbl.push_back('{1'b0, 1'b1, 16'h0000, 16'h1111, 16'hBEEF});
        tbl.push_back('{1'b0, 1'b1, 16'hFFFF, 16'h2222, 16'hBEEF});
        tbl.push_back('{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111});
        tbl.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h2222});
        tbl.push_back('{1'b1, 1'b1, 16'h0042, 16'h5555, 16'h2222});
        tbl.push_back('{1'b1, 1'b0, 16'h0042, 16'h0000, 16'h5555});
        tbl.push_back('{1'b1, 1'b0, 16'hBF01, 16'h0000, st_md});
        tbl.push_back('{1'b0, 1'b1, 16'hBF00, 16'h0041, st_md});
        tbl.push_back('{1'b1, 1'b0, 16'hBF00, 16'h0000, 16'h0041});
        tbl.push_back('{1'b1, 1'b0, 16'h0043, 16'h0000, pat(16'h0043)});
        foreach (tbl[i]) run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_md,
                                 $sformatf("tbl%0d", i));

        // Reset asserted in the middle of the write pulse.
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b0; alu_res = 16'h0100; wdata = 16'hA5A5;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstmid pulse", {26'b0, cur_vec()}, {26'b0, exp_vec(2, 1'b1, T_SRAM)});
        rst = 1'b0; mem_write = 1'b0; park = 1'b1;
        #1;
        check("rstmid strobes", {26'b0, cur_vec()}, 32'h1F);
        check("rstmid bus", {16'b0, ram_bus}, 32'h5A5A);
        check("rstmid addr", {14'b0, ram_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b1; park = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid idle", {26'b0, cur_vec()}, 32'h1F);
        check("rstmid memdata", {16'b0, mem_data}, 32'h0);
        ref_md = 16'h0000;
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, pat(16'h0100), "rstmid nowrite");

        // Random traffic over a small address window plus the UART addresses.
        for (int i = 0; i < 40; i++) begin
            logic        rd, wr;
            logic [15:0] a, d, e;
            int          r;
            r  = $urandom_range(0, 3);
            rd = r[0]; wr = r[1];
            if (!rd && !wr) rd = 1'b1;
            r = $urandom_range(0, 9);
            if (r == 9) a = 16'hBF00 + 16'($urandom_range(0, 1));
            else        a = 16'h3000 | 16'($urandom_range(0, 7));
            d = 16'($urandom);
            uart_rdy = 1'($urandom_range(0, 1));
            uart_tbre = 1'($urandom_range(0, 1));
            uart_tsre = 1'($urandom_range(0, 1));
            uart_rx = 16'($urandom);
            e = wr ? ref_md : model_load(a);
            run_txn(rd, wr, a, d, e, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        #1;
        check("final idle", {26'b0, cur_vec()}, 32'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 16-bit pipelined CPU, directly downstream of the execute stage. Takes the execute stage's ALU result as address and its forwarded store data, and performs loads/stores on the external 16-bit SRAM, or on the memory-mapped UART, through a multi-cycle sequencer. While an access is in flight it holds the rest of the pipeline with a stall output.

## Interface
Parameters:
- UART_DATA_ADDR, 16'hBF00, UART data register address
- UART_STAT_ADDR, 16'hBF01, UART status register address

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- MemRead  in  1  load request from the EX/MEM register
- MemWrite  in  1  store request from the EX/MEM register
- ALURes  in  16  access address (execute-stage ALU result)
- WData  in  16  store data (execute-stage forwarded data)
- MemData  out  16  registered load result
- Stall  out  1  high while the current access is not complete
- RamAddr  out  18  SRAM address
- RamData  inout  16  SRAM/UART shared data bus
- RamEN_n, RamOE_n, RamWE_n  out  1 each  SRAM enable/output-enable/write-enable, active low
- UartRd_n, UartWr_n  out  1 each  UART read/write strobes, active low
- UartDataReady, UartTbre, UartTsre  in  1 each  UART status flags

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: MemWrite=1 -> WR_SETUP. Else MemRead=1 -> RD. Else stay in IDLE. MemWrite wins if both requests are high.
- RD -> DONE. MemData captures the bus at the end of the RD cycle.
- Write path: WR_SETUP -> WR_PULSE -> WR_HOLD -> DONE.
- DONE -> IDLE unconditionally. The pipeline advances at the end of the DONE cycle, so the next request is seen in IDLE.
- Stall = (IDLE and (MemRead or MemWrite)) or state in {RD, WR_SETUP, WR_PULSE, WR_HOLD}. Stall is combinational and low in DONE.
- Address and data:
  - RamAddr = {2'b00, ALURes}, registered in IDLE when a request is accepted.
  - WData is registered at the same point and held for the whole access.
- SRAM read: RamEN_n=0 and RamOE_n=0 in RD.
- SRAM write:
  - RamEN_n=0 across all WR_* states.
  - RamWE_n=0 only in WR_PULSE.
  - RamData is driven with the latched data in all WR_* states.
  - RamOE_n stays high.
- Tristate: RamData is high-Z in every state except WR_*.
- Load data: MemData holds its value until the next load completes. Stores never change MemData.
- Address wrap: none; the 16-bit address is zero-extended.

## Timing
- Reset values: state=IDLE, MemData=0, RamAddr=0, Stall=0 (no request), all active-low strobes=1, RamData=Z.
- Reset is asynchronous. Asserting rst mid-access immediately releases all strobes and the bus, with no partial write completing afterwards.
- Load latency: request seen in IDLE at cycle 0. Stall is high in cycles 0–1. MemData is valid and Stall low in cycle 2 (DONE).
- Store latency: Stall is high in cycles 0–3. DONE is cycle 4.
- WE pulse: exactly one clock wide. Address and data are stable one cycle before and one cycle after it.
- Requests that appear while the FSM is not in IDLE are ignored; the pipeline holds them via Stall.

## Configuration
- UART_MMIO_EN defined:
  - Address UART_DATA_ADDR goes to the UART instead of SRAM.
    - RD: UartRd_n=0 instead of OE; MemData = {8'h00, RamData[7:0]}.
    - Write: UartWr_n=0 in WR_PULSE instead of WE; RamEN_n=1 throughout.
  - Address UART_STAT_ADDR:
    - Read: MemData = {14'b0, UartDataReady, UartTbre & UartTsre}; the bus is not used and no strobes are asserted.
    - Write: no strobes are asserted.
- UART_MMIO_EN undefined: all addresses map to SRAM, and UartRd_n/UartWr_n are tied to 1.

## Structure
- Shared package mem_pkg holds:
  - the state enum (3-bit encoding);
  - UART address constants;
  - the RamAddr width constant (18).
- One natural sub-module, mem_access_fsm, which holds:
  - state register, next-state logic, Stall;
  - the strobe decode.
- The top level holds the address/data/MemData registers and the tristate.

## Test plan
- Reset: rst low mid-write (in WR_PULSE) -> RamWE_n=1 and RamData=Z in the same cycle; state=IDLE and MemData=0 after release.
- SRAM store then load:
  - Store: MemWrite with ALURes=16'h1234, WData=16'hBEEF -> one-cycle RamWE_n pulse with RamAddr=18'h01234; Stall high for 4 cycles.
  - Load: then MemRead at 16'h1234 -> MemData=16'hBEEF in DONE; Stall high for 2 cycles.
- Simultaneous MemRead=MemWrite=1 -> write sequence only, RamOE_n stays 1.
- Back-to-back loads (address 0x0000 then 0xFFFF) -> IDLE is visited between them; RamAddr=18'h0FFFF for the second load; no overlap of OE strobes.
- UART_MMIO_EN status: with UartDataReady=1, UartTbre=1, UartTsre=0, load from 16'hBF01 -> MemData=16'h0002, all strobes high.
- UART_MMIO_EN data: store 16'h0041 to 16'hBF00 -> UartWr_n low for 1 cycle, RamWE_n and RamEN_n stay 1.
